// File: rtl/subkey_schedule_ctrl.sv
// Threefish-1024 key schedule sequencer.
// For each subkey injection requested by the round pipeline, streams the 16
// subkey word slots with a valid/ready handshake. Each slot carries the mux
// select, the extended-key word index (s+i) mod 17, both tweak indices and
// the subkey number. All index arithmetic is incremental wrap-compare.
module subkey_schedule_ctrl #(
    parameter int NUM_SUBKEYS = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       subkey_req_i,
    input  logic       word_ready_i,
    output logic       word_valid_o,
    output logic [3:0] word_select_o,
    output logic [4:0] key_index_o,
    output logic [1:0] tweak_idx_a_o,
    output logic [1:0] tweak_idx_b_o,
    output logic [4:0] subkey_num_o,
    output logic       busy_o,
    output logic       subkey_done_o,
    output logic       schedule_done_o,
    output logic       overrun_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_REQ = 2'd1,
        STREAM   = 2'd2
    } state_t;

    localparam logic [4:0] LAST_SUBKEY = 5'(NUM_SUBKEYS - 1);

    state_t     state_q, state_d;
    logic [3:0] slot_q, slot_d;
    logic [4:0] subkey_q, subkey_d;
    logic [4:0] key_index_q, key_index_d;
    logic [4:0] key_base_q, key_base_d;
    logic [4:0] key_base_next;
    logic [1:0] tweak_a_q, tweak_a_d;
    logic [1:0] tweak_b_q, tweak_b_d;
    logic       pending_q, pending_d;
    logic       overrun_q, overrun_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       subkey_done_q, subkey_done_d;
    logic       schedule_done_q, schedule_done_d;

    // Next-state and next-output computation; key_base tracks s mod 17 so the
    // first key index of the following subkey is one wrap-increment away.
    always_comb begin
        state_d         = state_q;
        slot_d          = slot_q;
        subkey_d        = subkey_q;
        key_index_d     = key_index_q;
        key_base_d      = key_base_q;
        tweak_a_d       = tweak_a_q;
        tweak_b_d       = tweak_b_q;
        pending_d       = pending_q;
        overrun_d       = overrun_q;
        subkey_done_d   = 1'b0;
        schedule_done_d = 1'b0;
        key_base_next   = (key_base_q == 5'd16) ? 5'd0 : key_base_q + 5'd1;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = WAIT_REQ;
                    slot_d      = 4'd0;
                    subkey_d    = 5'd0;
                    key_index_d = 5'd0;
                    key_base_d  = 5'd0;
                    tweak_a_d   = 2'd0;
                    tweak_b_d   = 2'd1;
                    pending_d   = 1'b0;
                    overrun_d   = 1'b0;
                end
            end

            WAIT_REQ: begin
                // A stored request is consumed on exit; a fresh request
                // arriving on that same cycle becomes the new pending one.
                if (pending_q || subkey_req_i) begin
                    state_d   = STREAM;
                    pending_d = pending_q && subkey_req_i;
                end
            end

            STREAM: begin
                if (subkey_req_i) begin
                    if (pending_q) begin
                        overrun_d = 1'b1;
                    end else begin
                        pending_d = 1'b1;
                    end
                end
                if (word_ready_i) begin
                    if (slot_q != 4'd15) begin
                        slot_d      = slot_q + 4'd1;
                        key_index_d = (key_index_q == 5'd16) ? 5'd0 : key_index_q + 5'd1;
                    end else begin
                        subkey_done_d = 1'b1;
                        if (subkey_q == LAST_SUBKEY) begin
                            schedule_done_d = 1'b1;
                            state_d         = IDLE;
                            pending_d       = 1'b0;
                        end else begin
                            state_d     = WAIT_REQ;
                            subkey_d    = subkey_q + 5'd1;
                            slot_d      = 4'd0;
                            key_base_d  = key_base_next;
                            key_index_d = key_base_next;
                            tweak_a_d   = (tweak_a_q == 2'd2) ? 2'd0 : tweak_a_q + 2'd1;
                            tweak_b_d   = (tweak_b_q == 2'd2) ? 2'd0 : tweak_b_q + 2'd1;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = (state_d == STREAM);
        busy_d  = (state_d != IDLE);
    end

    // State and registered outputs; reset drops straight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            slot_q          <= 4'd0;
            subkey_q        <= 5'd0;
            key_index_q     <= 5'd0;
            key_base_q      <= 5'd0;
            tweak_a_q       <= 2'd0;
            tweak_b_q       <= 2'd1;
            pending_q       <= 1'b0;
            overrun_q       <= 1'b0;
            valid_q         <= 1'b0;
            busy_q          <= 1'b0;
            subkey_done_q   <= 1'b0;
            schedule_done_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            slot_q          <= slot_d;
            subkey_q        <= subkey_d;
            key_index_q     <= key_index_d;
            key_base_q      <= key_base_d;
            tweak_a_q       <= tweak_a_d;
            tweak_b_q       <= tweak_b_d;
            pending_q       <= pending_d;
            overrun_q       <= overrun_d;
            valid_q         <= valid_d;
            busy_q          <= busy_d;
            subkey_done_q   <= subkey_done_d;
            schedule_done_q <= schedule_done_d;
        end
    end

    assign word_valid_o    = valid_q;
    assign word_select_o   = slot_q;
    assign key_index_o     = key_index_q;
    assign tweak_idx_a_o   = tweak_a_q;
    assign tweak_idx_b_o   = tweak_b_q;
    assign subkey_num_o    = subkey_q;
    assign busy_o          = busy_q;
    assign subkey_done_o   = subkey_done_q;
    assign schedule_done_o = schedule_done_q;
    assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_subkey_schedule_ctrl.sv
// Directed testbench for subkey_schedule_ctrl: reset, per-slot word contents,
// index wrap, backpressure, full schedule timing and overrun handling.
module tb_subkey_schedule_ctrl;

    localparam int NUM_SUBKEYS = 21;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_i = 1'b0;
    logic       subkey_req_i = 1'b0;
    logic       word_ready_i = 1'b0;
    logic       word_valid_o;
    logic [3:0] word_select_o;
    logic [4:0] key_index_o;
    logic [1:0] tweak_idx_a_o;
    logic [1:0] tweak_idx_b_o;
    logic [4:0] subkey_num_o;
    logic       busy_o;
    logic       subkey_done_o;
    logic       schedule_done_o;
    logic       overrun_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int sk_done_cnt = 0;
    int sch_done_cnt = 0;
    int sk_base, sch_base, cyc_start, cyc_end;

    subkey_schedule_ctrl #(.NUM_SUBKEYS(NUM_SUBKEYS)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .subkey_req_i    (subkey_req_i),
        .word_ready_i    (word_ready_i),
        .word_valid_o    (word_valid_o),
        .word_select_o   (word_select_o),
        .key_index_o     (key_index_o),
        .tweak_idx_a_o   (tweak_idx_a_o),
        .tweak_idx_b_o   (tweak_idx_b_o),
        .subkey_num_o    (subkey_num_o),
        .busy_o          (busy_o),
        .subkey_done_o   (subkey_done_o),
        .schedule_done_o (schedule_done_o),
        .overrun_o       (overrun_o)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Edge counter used to measure schedule latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Count done pulses away from the active edge.
    always @(negedge clk) begin
        if (subkey_done_o)   sk_done_cnt  <= sk_done_cnt + 1;
        if (schedule_done_o) sch_done_cnt <= sch_done_cnt + 1;
    end

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive inputs for one rising edge, return at the following falling edge
    // with the single-cycle pulses cleared.
    task automatic applyStimulus(input logic start, input logic req, input logic ready);
        start_i      = start;
        subkey_req_i = req;
        word_ready_i = ready;
        @(posedge clk);
        @(negedge clk);
        start_i      = 1'b0;
        subkey_req_i = 1'b0;
    endtask

    // Pulse a request in WAIT_REQ and expect slot 0 on the next cycle.
    task automatic request_subkey(input int s);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput($sformatf("req_valid_s%0d", s), word_valid_o, 1);
    endtask

    // Stream slots first..last-1 of subkey s, checking every presented word
    // against the closed-form expectation. req_mask pulses a request the first
    // time a slot is presented; start_last raises start_i while slot 15 shows.
    task automatic stream_subkey(input int s, input int first, input int last, input bit rnd,
                                 input logic [15:0] req_mask, input bit start_last);
        int          i;
        int          guard;
        logic        rdy;
        logic        req;
        logic        accepted;
        logic [15:0] sent;
        i     = first;
        guard = 0;
        sent  = '0;
        while (i < last && guard < 400) begin
            checkOutput($sformatf("s%0d_i%0d_valid", s, i), word_valid_o, 1);
            checkOutput($sformatf("s%0d_i%0d_select", s, i), word_select_o, i);
            checkOutput($sformatf("s%0d_i%0d_key", s, i), key_index_o, (s + i) % 17);
            checkOutput($sformatf("s%0d_i%0d_twa", s, i), tweak_idx_a_o, s % 3);
            checkOutput($sformatf("s%0d_i%0d_twb", s, i), tweak_idx_b_o, (s + 1) % 3);
            checkOutput($sformatf("s%0d_i%0d_num", s, i), subkey_num_o, s);
            rdy      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            req      = req_mask[i] && !sent[i];
            sent[i]  = 1'b1;
            accepted = word_valid_o && rdy;
            applyStimulus(start_last && (i == 15), req, rdy);
            if (accepted) i++;
            guard++;
        end
        checkOutput($sformatf("s%0d_words_accepted", s), i, last);
        word_ready_i = 1'b1;
    endtask

    initial begin
        $display("[TB] subkey_schedule_ctrl bench, NUM_SUBKEYS=%0d", NUM_SUBKEYS);

        // Reset values
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_valid", word_valid_o, 0);
        checkOutput("rst_select", word_select_o, 0);
        checkOutput("rst_key", key_index_o, 0);
        checkOutput("rst_twa", tweak_idx_a_o, 0);
        checkOutput("rst_twb", tweak_idx_b_o, 1);
        checkOutput("rst_num", subkey_num_o, 0);
        checkOutput("rst_skdone", subkey_done_o, 0);
        checkOutput("rst_schdone", schedule_done_o, 0);
        checkOutput("rst_overrun", overrun_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Request in IDLE is ignored and must not leave a pending request
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("idle_req_busy", busy_o, 0);
        checkOutput("idle_req_valid", word_valid_o, 0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("start_busy", busy_o, 1);
        checkOutput("start_valid", word_valid_o, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("no_stale_pending", word_valid_o, 0);

        // Subkey 0 with ready held high
        request_subkey(0);
        stream_subkey(0, 0, 16, 1'b0, 16'h0000, 1'b0);
        checkOutput("s0_skdone", subkey_done_o, 1);
        checkOutput("s0_schdone", schedule_done_o, 0);
        checkOutput("s0_valid_after", word_valid_o, 0);
        checkOutput("s0_busy_after", busy_o, 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("s0_skdone_once", subkey_done_o, 0);

        // Start outside IDLE is ignored
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("busy_start_num", subkey_num_o, 1);
        checkOutput("busy_start_valid", word_valid_o, 0);

        for (int s = 1; s <= 4; s++) begin
            request_subkey(s);
            stream_subkey(s, 0, 16, 1'b0, 16'h0000, 1'b0);
        end

        // Key index wrap at s=5
        request_subkey(5);
        stream_subkey(5, 0, 11, 1'b0, 16'h0000, 1'b0);
        checkOutput("wrap_slot11_key", key_index_o, 16);
        stream_subkey(5, 11, 12, 1'b0, 16'h0000, 1'b0);
        checkOutput("wrap_slot12_key", key_index_o, 0);
        stream_subkey(5, 12, 14, 1'b0, 16'h0000, 1'b0);
        checkOutput("wrap_slot14_key", key_index_o, 2);
        checkOutput("wrap_s5_twa", tweak_idx_a_o, 2);
        checkOutput("wrap_s5_twb", tweak_idx_b_o, 0);
        checkOutput("wrap_s5_num", subkey_num_o, 5);
        stream_subkey(5, 14, 16, 1'b0, 16'h0000, 1'b0);

        // Backpressure with pseudo-random ready
        request_subkey(6);
        stream_subkey(6, 0, 16, 1'b1, 16'h0000, 1'b0);
        checkOutput("bp_skdone", subkey_done_o, 1);

        // Reset mid-stream at s=7, i=9
        request_subkey(7);
        stream_subkey(7, 0, 9, 1'b0, 16'h0000, 1'b0);
        checkOutput("mid_select", word_select_o, 9);
        sk_base  = sk_done_cnt;
        sch_base = sch_done_cnt;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", busy_o, 0);
        checkOutput("mid_rst_valid", word_valid_o, 0);
        checkOutput("mid_rst_twb", tweak_idx_b_o, 1);
        checkOutput("mid_rst_num", subkey_num_o, 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("mid_rst_skdone", subkey_done_o, 0);
        checkOutput("mid_rst_schdone", schedule_done_o, 0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("mid_rst_no_skpulse", sk_done_cnt - sk_base, 0);
        checkOutput("mid_rst_no_schpulse", sch_done_cnt - sch_base, 0);

        // Full schedule, requests pulsed during each stream
        sk_base  = sk_done_cnt;
        sch_base = sch_done_cnt;
        applyStimulus(1'b1, 1'b0, 1'b1);
        cyc_start = cyc;
        checkOutput("full_start_num", subkey_num_o, 0);
        request_subkey(0);
        for (int s = 0; s < NUM_SUBKEYS; s++) begin
            if (s == NUM_SUBKEYS - 1) begin
                checkOutput("s20_slot0_key", key_index_o, 3);
                checkOutput("s20_twa", tweak_idx_a_o, 2);
                checkOutput("s20_twb", tweak_idx_b_o, 0);
            end
            stream_subkey(s, 0, 16, 1'b0, (s < NUM_SUBKEYS - 1) ? 16'h0020 : 16'h0000,
                          s == NUM_SUBKEYS - 1);
            checkOutput($sformatf("full_s%0d_skdone", s), subkey_done_o, 1);
            checkOutput($sformatf("full_s%0d_schdone", s), schedule_done_o, (s == NUM_SUBKEYS - 1) ? 1 : 0);
            checkOutput($sformatf("full_s%0d_busy", s), busy_o, (s == NUM_SUBKEYS - 1) ? 0 : 1);
            if (s < NUM_SUBKEYS - 1) begin
                applyStimulus(1'b0, 1'b0, 1'b1);
                checkOutput($sformatf("full_s%0d_pending_go", s), word_valid_o, 1);
            end
        end
        cyc_end = cyc;
        checkOutput("full_latency", cyc_end - cyc_start, 1 + NUM_SUBKEYS * 17 - 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("late_start_ignored", busy_o, 0);
        checkOutput("full_skdone_drop", subkey_done_o, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("full_skdone_count", sk_done_cnt - sk_base, NUM_SUBKEYS);
        checkOutput("full_schdone_count", sch_done_cnt - sch_base, 1);

        // Overrun: two requests during one stream
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("ovr_clear_before", overrun_o, 0);
        request_subkey(0);
        stream_subkey(0, 0, 16, 1'b0, 16'h0108, 1'b0);
        checkOutput("ovr_set", overrun_o, 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("ovr_pending_go", word_valid_o, 1);
        stream_subkey(1, 0, 16, 1'b0, 16'h0000, 1'b0);
        checkOutput("ovr_sticky", overrun_o, 1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("ovr_no_extra_stream%0d", k), word_valid_o, 0);
        end
        checkOutput("ovr_wait_busy", busy_o, 1);
        for (int s = 2; s < NUM_SUBKEYS; s++) begin
            request_subkey(s);
            stream_subkey(s, 0, 16, 1'b0, 16'h0000, 1'b0);
        end
        checkOutput("ovr_end_schdone", schedule_done_o, 1);
        checkOutput("ovr_still_set", overrun_o, 1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("ovr_cleared_by_start", overrun_o, 0);
        checkOutput("restart_busy", busy_o, 1);
        checkOutput("restart_num", subkey_num_o, 0);
        checkOutput("restart_key", key_index_o, 0);
        checkOutput("restart_twa", tweak_idx_a_o, 0);
        checkOutput("restart_twb", tweak_idx_b_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
